ctrl_pipe: RTL and testbench

//  Carries the decoded control bundle from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_stage_reg.sv | 29 ++
 rtl/ctrl_pipe.sv | 124 ++++++++++++
 tb/tb_ctrl_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types for the ID/EX, EX/MEM and MEM/WB registers.
// Optional load-use detection in ctrl_pipe is enabled by LOAD_USE_HAZARD_EN.
package ctrl_pkg;

    localparam int CTRL_RD_W = 5;
    localparam int CTRL_OP_W = 2;

    localparam logic [CTRL_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [CTRL_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [CTRL_OP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic                 valid;
        logic [CTRL_OP_W-1:0] alu_op;
        logic                 alu_src;
        logic [CTRL_RD_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic                 valid;
        logic                 branch;
        logic                 read;
        logic                 write;
        logic [CTRL_RD_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [CTRL_RD_W-1:0] rd;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } id_ex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_mem_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

    localparam id_ex_t  ID_EX_BUBBLE  = '{ex: EX_BUBBLE, mem: MEM_BUBBLE, wb: WB_BUBBLE};
    localparam ex_mem_t EX_MEM_BUBBLE = '{mem: MEM_BUBBLE, wb: WB_BUBBLE};

    // Only an exact 1 counts; X/Z collapse to 0.
    function automatic logic known_one(input logic b);
        case (b)
            1'b1:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: async reset, bubble > hold > load.
// Used for the ID/EX, EX/MEM and MEM/WB control bundles.
module ctrl_stage_reg #(
    parameter type T      = logic,
    parameter T    BUBBLE = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    output T     q
);

    // Bubble wins over hold so a flush can override a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID -> EX -> MEM -> WB with stall, flush and bubbles.
// Define LOAD_USE_HAZARD_EN to add the load-use hazard comparator.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  ex_valid,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_alu_src,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  hazard_stall
);

    id_ex_t   id_bundle;
    id_ex_t   id_ex_q;
    ex_mem_t  ex_mem_d;
    ex_mem_t  ex_mem_q;
    wb_ctrl_t mem_wb_q;

    // Sanitise the decoded bundle: an invalid slot is a pure bubble.
    always_comb begin
        id_bundle = ID_EX_BUBBLE;
        if (id_valid) begin
            id_bundle.ex.valid      = 1'b1;
            id_bundle.ex.alu_op     = id_alu_op;
            id_bundle.ex.alu_src    = id_alu_src;
            id_bundle.ex.rd         = id_rd;
            id_bundle.mem.valid     = 1'b1;
            id_bundle.mem.branch    = id_branch;
            id_bundle.mem.read      = id_mem_read;
            id_bundle.mem.write     = id_mem_write;
            id_bundle.mem.rd        = id_rd;
            id_bundle.wb.valid      = 1'b1;
            id_bundle.wb.reg_write  = id_reg_write;
            id_bundle.wb.mem_to_reg = id_reg_write & known_one(id_mem_to_reg);
            id_bundle.wb.rd         = id_rd;
        end
    end

`ifdef LOAD_USE_HAZARD_EN
    logic load_use;
    assign load_use = id_ex_q.ex.valid & id_ex_q.mem.read
                    & (id_ex_q.ex.rd != '0) & id_valid
                    & ((id_ex_q.ex.rd == id_rs1) | (id_ex_q.ex.rd == id_rs2));
    assign hazard_stall = load_use & ~stall_i;
`else
    logic unused_rs;
    assign unused_rs    = ^{id_rs1, id_rs2};
    assign hazard_stall = 1'b0;
`endif

    assign ex_mem_d = '{mem: id_ex_q.mem, wb: id_ex_q.wb};

    ctrl_stage_reg #(.T(id_ex_t), .BUBBLE(ID_EX_BUBBLE)) u_id_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .hold   (stall_i),
        .bubble (flush_i | hazard_stall),
        .d      (id_bundle),
        .q      (id_ex_q)
    );

    ctrl_stage_reg #(.T(ex_mem_t), .BUBBLE(EX_MEM_BUBBLE)) u_ex_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .hold   (stall_i),
        .bubble (flush_i),
        .d      (ex_mem_d),
        .q      (ex_mem_q)
    );

    ctrl_stage_reg #(.T(wb_ctrl_t), .BUBBLE(WB_BUBBLE)) u_mem_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .hold   (stall_i & ~flush_i),
        .bubble (1'b0),
        .d      (ex_mem_q.wb),
        .q      (mem_wb_q)
    );

    assign ex_valid      = id_ex_q.ex.valid;
    assign ex_alu_op     = id_ex_q.ex.alu_op;
    assign ex_alu_src    = id_ex_q.ex.alu_src;
    assign ex_rd         = id_ex_q.ex.rd;
    assign mem_valid     = ex_mem_q.mem.valid;
    assign mem_branch    = ex_mem_q.mem.branch;
    assign mem_read      = ex_mem_q.mem.read;
    assign mem_write     = ex_mem_q.mem.write;
    assign mem_rd        = ex_mem_q.mem.rd;
    assign wb_valid      = mem_wb_q.valid;
    assign wb_reg_write  = mem_wb_q.reg_write & (mem_wb_q.rd != '0);
    assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
    assign wb_rd         = mem_wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: instruction-level model vs DUT.
// Honours LOAD_USE_HAZARD_EN the same way as the design.
module tb_ctrl_pipe;

    localparam bit [2:0] K_LW   = 3'd0;
    localparam bit [2:0] K_SW   = 3'd1;
    localparam bit [2:0] K_R    = 3'd2;
    localparam bit [2:0] K_BEQ  = 3'd3;
    localparam bit [2:0] K_ADDI = 3'd4;

    typedef struct packed {
        bit       valid;
        bit [2:0] kind;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
    } instr_t;

    typedef struct packed {
        bit       ex_valid;
        bit [1:0] ex_alu_op;
        bit       ex_alu_src;
        bit [4:0] ex_rd;
        bit       mem_valid;
        bit       mem_branch;
        bit       mem_read;
        bit       mem_write;
        bit [4:0] mem_rd;
        bit       wb_valid;
        bit       wb_reg_write;
        bit       wb_mem_to_reg;
        bit [4:0] wb_rd;
        bit       hazard;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0;
    logic [1:0] id_alu_op = '0;
    logic       id_alu_src = 1'b0;
    logic       id_branch = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       id_mem_write = 1'b0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_to_reg = 1'b0;
    logic [4:0] id_rd = '0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       ex_valid, ex_alu_src, mem_valid, mem_branch, mem_read, mem_write;
    logic       wb_valid, wb_reg_write, wb_mem_to_reg, hazard_stall;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd, mem_rd, wb_rd;

    int checks = 0;
    int errors = 0;

    exp_t   sb[$];
    instr_t s_ex, s_mem, s_wb;
    instr_t cur;
    bit     keep;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_branch(mem_branch),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit [2:0] k, int rd, int rs1, int rs2);
        instr_t i;
        i.valid = 1'b1;
        i.kind  = k;
        i.rd    = 5'(rd);
        i.rs1   = 5'(rs1);
        i.rs2   = 5'(rs2);
        return i;
    endfunction

    function automatic bit writes(instr_t i);
        return i.valid && (i.kind == K_LW || i.kind == K_R || i.kind == K_ADDI);
    endfunction

    function automatic bit raw_haz(instr_t ex, instr_t id);
`ifdef LOAD_USE_HAZARD_EN
        return ex.valid && ex.kind == K_LW && ex.rd != 0 && id.valid
            && (ex.rd == id.rs1 || ex.rd == id.rs2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t expect_of(instr_t e, instr_t m, instr_t w, bit h);
        exp_t r;
        r = '0;
        r.ex_valid   = e.valid;
        r.ex_alu_op  = !e.valid ? 2'b00 : (e.kind == K_R) ? 2'b10 :
                       (e.kind == K_BEQ) ? 2'b01 : 2'b00;
        r.ex_alu_src = e.valid && (e.kind == K_LW || e.kind == K_SW || e.kind == K_ADDI);
        r.ex_rd      = e.valid ? e.rd : 5'd0;
        r.mem_valid  = m.valid;
        r.mem_branch = m.valid && m.kind == K_BEQ;
        r.mem_read   = m.valid && m.kind == K_LW;
        r.mem_write  = m.valid && m.kind == K_SW;
        r.mem_rd     = m.valid ? m.rd : 5'd0;
        r.wb_valid      = w.valid;
        r.wb_reg_write  = writes(w) && w.rd != 0;
        r.wb_mem_to_reg = w.valid && w.kind == K_LW;
        r.wb_rd         = w.valid ? w.rd : 5'd0;
        r.hazard        = h;
        return r;
    endfunction

    task automatic drive(instr_t in, bit st, bit fl);
        stall_i  = st;
        flush_i  = fl;
        id_valid = in.valid;
        id_rd    = in.valid ? in.rd  : 5'($urandom);
        id_rs1   = in.valid ? in.rs1 : 5'($urandom);
        id_rs2   = in.valid ? in.rs2 : 5'($urandom);
        {id_alu_op, id_alu_src, id_branch, id_mem_read,
         id_mem_write, id_reg_write, id_mem_to_reg} = 8'($urandom);
        if (in.valid) begin
            {id_alu_src, id_branch, id_mem_read, id_mem_write, id_reg_write} = '0;
            case (in.kind)
                K_LW: begin
                    id_alu_op = 2'b00; id_alu_src = 1'b1; id_mem_read = 1'b1;
                    id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
                end
                K_SW: begin
                    id_alu_op = 2'b00; id_alu_src = 1'b1; id_mem_write = 1'b1;
                    id_mem_to_reg = 1'bx;
                end
                K_R: begin
                    id_alu_op = 2'b10; id_reg_write = 1'b1; id_mem_to_reg = 1'b0;
                end
                K_BEQ: begin
                    id_alu_op = 2'b01; id_branch = 1'b1; id_mem_to_reg = 1'bx;
                end
                default: begin
                    id_alu_op = 2'b00; id_alu_src = 1'b1; id_reg_write = 1'b1;
                    id_mem_to_reg = 1'b0;
                end
            endcase
        end
    endtask

    task automatic chk_zero();
        chk("rst_ex_valid", int'(ex_valid), 0);
        chk("rst_ex_alu_op", int'(ex_alu_op), 0);
        chk("rst_ex_alu_src", int'(ex_alu_src), 0);
        chk("rst_ex_rd", int'(ex_rd), 0);
        chk("rst_mem_valid", int'(mem_valid), 0);
        chk("rst_mem_ctl", int'({mem_branch, mem_read, mem_write}), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_ctl", int'({wb_reg_write, wb_mem_to_reg}), 0);
        chk("rst_wb_rd", int'(wb_rd), 0);
        chk("rst_hazard", int'(hazard_stall), 0);
    endtask

    // One cycle: drive at negedge, advance the model, queue the expectation.
    task automatic step(instr_t in, bit st, bit fl, bit rst_mid);
        bit     h;
        instr_t nb;
        nb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(in, st, fl);
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk_zero();
        end
        h = raw_haz(s_ex, in) && !st;
        if (!rst_n) begin
            s_ex = nb; s_mem = nb; s_wb = nb;
        end else if (fl) begin
            s_wb = s_mem; s_mem = nb; s_ex = nb;
        end else if (!st) begin
            s_wb  = s_mem;
            s_mem = s_ex;
            s_ex  = (h || !in.valid) ? nb : in;
        end
        keep = h || st;
        sb.push_back(expect_of(s_ex, s_mem, s_wb,
                               raw_haz(s_ex, in) && !st && rst_n));
    endtask

    task automatic nops(int n);
        repeat (n) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle after the edge compare the DUT against the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_valid", int'(ex_valid), int'(e.ex_valid));
            chk("ex_alu_op", int'(ex_alu_op), int'(e.ex_alu_op));
            chk("ex_alu_src", int'(ex_alu_src), int'(e.ex_alu_src));
            chk("ex_rd", int'(ex_rd), int'(e.ex_rd));
            chk("mem_valid", int'(mem_valid), int'(e.mem_valid));
            chk("mem_branch", int'(mem_branch), int'(e.mem_branch));
            chk("mem_read", int'(mem_read), int'(e.mem_read));
            chk("mem_write", int'(mem_write), int'(e.mem_write));
            chk("mem_rd", int'(mem_rd), int'(e.mem_rd));
            chk("wb_valid", int'(wb_valid), int'(e.wb_valid));
            chk("wb_reg_write", int'(wb_reg_write), int'(e.wb_reg_write));
            chk("wb_mem_to_reg", int'(wb_mem_to_reg), int'(e.wb_mem_to_reg));
            chk("wb_rd", int'(wb_rd), int'(e.wb_rd));
            chk("hazard_stall", int'(hazard_stall), int'(e.hazard));
        end
    end

    initial begin
        instr_t nxt;
        bit     st, fl;
        s_ex = '0; s_mem = '0; s_wb = '0; keep = 1'b0; cur = '0;
        #1 rst_n = 1'b0;
        #1 chk_zero();
        repeat (2) @(posedge clk);

        step(mk(K_LW, 5, 1, 2), 1'b0, 1'b0, 1'b0);
        nops(4);
        step(mk(K_SW, 9, 2, 3), 1'b0, 1'b0, 1'b0);
        nops(4);

        step(mk(K_BEQ, 3, 1, 2), 1'b0, 1'b0, 1'b0);
        step(mk(K_ADDI, 4, 1, 0), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 6, 1, 2), 1'b0, 1'b1, 1'b0);
        nops(3);

        step(mk(K_LW, 10, 1, 2), 1'b0, 1'b0, 1'b0);
        step(mk(K_ADDI, 11, 1, 0), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 12, 1, 2), 1'b0, 1'b0, 1'b0);
        repeat (3) step(mk(K_R, 13, 1, 2), 1'b1, 1'b0, 1'b0);
        nops(4);

        step(mk(K_LW, 7, 1, 2), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 8, 7, 1), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 8, 7, 1), 1'b0, 1'b0, 1'b0);
        nops(3);
        step(mk(K_LW, 0, 1, 2), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 8, 0, 0), 1'b0, 1'b0, 1'b0);
        nops(3);

        step(mk(K_BEQ, 3, 1, 2), 1'b0, 1'b0, 1'b0);
        step(mk(K_ADDI, 4, 1, 0), 1'b0, 1'b0, 1'b0);
        step(mk(K_R, 6, 1, 2), 1'b0, 1'b1, 1'b1);
        step(mk(K_ADDI, 0, 1, 0), 1'b0, 1'b0, 1'b0);
        nops(4);

        keep = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!keep) begin
                nxt.valid = ($urandom_range(0, 9) < 8);
                nxt.kind  = 3'($urandom_range(0, 4));
                nxt.rd    = 5'($urandom_range(0, 7));
                nxt.rs1   = 5'($urandom_range(0, 7));
                nxt.rs2   = 5'($urandom_range(0, 7));
                cur = nxt;
            end
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 11) == 0);
            step(cur, st, fl, 1'b0);
        end
        nops(3);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
